// File: rtl/clk_meter_pkg.sv
// rtl/clk_meter_pkg.sv - state encoding and defaults shared by the clk_period_meter slice
package clk_meter_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        ARM  = ST_ARM,
        MEAS = ST_MEAS
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - multi-flop synchronizer with rising-edge detector
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic s_sync,
    output logic rise
);

    logic [STAGES-1:0] sr;
    logic              s_d;

    // shift the async input through the synchronizer and keep one delayed copy for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr  <= '0;
            s_d <= 1'b0;
        end else begin
            sr  <= {sr[STAGES-2:0], d};
            s_d <= sr[STAGES-1];
        end
    end

    assign s_sync = sr[STAGES-1];
    assign rise   = s_sync & ~s_d;

endmodule

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - clk_in period/high-time meter; high time built only with CLK_PERIOD_METER_DUTY_EN
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clk_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             ovf_o,
    output logic             overrun_o,
    output logic             stall_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int               TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]    T_LIM   = TW'(TIMEOUT - 1);

    state_t           state, state_nxt;
    logic             s_sync, rise, capture;
    logic [CNT_W-1:0] cnt;
    logic             ovf_pend;
    logic [CNT_W-1:0] stage_period;
    logic             stage_ovf, load_q;
    logic [TW-1:0]    tcnt;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (clk_in),
        .s_sync (s_sync),
        .rise   (rise)
    );

    // a full period has been measured when a rise arrives while measuring
    assign capture = en && (state == MEAS) && rise;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next state: en low always returns to IDLE; the first rise only arms the measurement
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = ARM;
            ARM:     if (!en) state_nxt = IDLE;
                     else if (rise) state_nxt = MEAS;
            MEAS:    if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // period counter; the rise cycle starts a new period and is accounted for by the +1 at capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (!en || state == IDLE || rise) begin
            cnt      <= '0;
            ovf_pend <= 1'b0;
        end else if (state == MEAS) begin
            if (cnt == CNT_MAX) ovf_pend <= 1'b1;
            else                cnt      <= cnt + CNT_W'(1);
        end
    end

    // stage the finished period for one cycle, then publish it together with m_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_period <= '0;
            stage_ovf    <= 1'b0;
            load_q       <= 1'b0;
        end else begin
            load_q <= capture;
            if (capture) begin
                stage_period <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
                stage_ovf    <= ovf_pend || (cnt == CNT_MAX);
            end
        end
    end

    // result handshake: a new result may replace an unaccepted one, and acceptance in the load cycle keeps m_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_o  <= '0;
            ovf_o     <= 1'b0;
            m_valid   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (load_q) begin
                period_o <= stage_period;
                ovf_o    <= stage_ovf;
                m_valid  <= 1'b1;
            end else if (m_valid && m_ready) begin
                m_valid  <= 1'b0;
            end
            if (!en)                              overrun_o <= 1'b0;
            else if (load_q && m_valid && !m_ready) overrun_o <= 1'b1;
        end
    end

    // stall watchdog: counts armed cycles without a rise and holds at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            stall_o <= 1'b0;
        end else if (!en || state == IDLE || rise) begin
            tcnt    <= '0;
            stall_o <= 1'b0;
        end else if (tcnt == T_LIM) begin
            stall_o <= 1'b1;
        end else begin
            tcnt    <= tcnt + TW'(1);
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt, stage_high;

    // high-time counter; the rise cycle is itself high, so a new period starts at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    hcnt <= '0;
        else if (!en || state == IDLE) hcnt <= '0;
        else if (rise)                 hcnt <= CNT_W'(1);
        else if (state == MEAS && s_sync && hcnt != CNT_MAX)
                                       hcnt <= hcnt + CNT_W'(1);
    end

    // high time follows the same stage-then-publish path as the period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_high <= '0;
            high_o     <= '0;
        end else begin
            if (capture) stage_high <= hcnt;
            if (load_q)  high_o     <= stage_high;
        end
    end
`else
    logic unused_s_sync;
    assign unused_s_sync = s_sync;
    assign high_o        = '0;
`endif

endmodule
